// File: rtl/core_ctrl_pkg.sv
// core_pkg: shared definitions for the convolution-pass sequencer.
//   state_t        sequencer FSM states
//   INST_*         bit positions inside the 34-bit corelet instruction word
//   clog2w / max2  elaboration-time helpers for counter sizing
package core_pkg;

  localparam int INST_W     = 34;
  localparam int INST_KLOAD = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_L0WR  = 2;
  localparam int INST_L0RD  = 3;
  localparam int INST_ACC   = 33;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_LOAD,
    S_W_KERN,
    S_W_WAIT,
    S_X_LOAD,
    S_X_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  // Counter width for a bound, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core_ctrl_sram_rd_stream.sv
// sram_rd_stream: issues a burst of (last_i+1) consecutive xmem reads starting
// at base_i, throttled by the L0 almost-full flag, and raises the L0 write
// strobe one cycle after each read to match the SRAM read latency.
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        begin a burst this edge (base_i/last_i captured here)
//   base_i         first read address
//   last_i         index of the final read (count - 1)
//   L0_full_i      high: do not issue a read at this edge
//   cen_o          xmem chip enable, active low (registered)
//   addr_o         xmem read address (registered, held while stalled)
//   wr_o           L0 write strobe, one cycle after each read (registered)
//   last_wr_o      high in the cycle carrying the write of the final read
module sram_rd_stream #(
  parameter int AW = 11,
  parameter int CW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  input  logic [CW-1:0] last_i,
  input  logic          L0_full_i,
  output logic          cen_o,
  output logic [AW-1:0] addr_o,
  output logic          wr_o,
  output logic          last_wr_o
);

  logic          active_q, all_q, cen_q, wr_q;
  logic [CW-1:0] idx_q, last_q;
  logic [AW-1:0] base_q, addr_q;

  logic [CW-1:0] idx_c, last_c;
  logic [AW-1:0] base_c;
  logic          issue;

  // The first read of a burst goes out on the same edge as start_i, so the
  // burst parameters are taken straight from the inputs on that edge.
  always_comb begin
    idx_c  = start_i ? '0 : idx_q;
    last_c = start_i ? last_i : last_q;
    base_c = start_i ? base_i : base_q;
    issue  = (start_i | (active_q & ~all_q)) & ~L0_full_i;
  end

  // All reads issued, none this cycle, and a write strobe present: that
  // strobe belongs to the final read.
  assign last_wr_o = active_q & all_q & cen_q & wr_q;
  assign cen_o     = cen_q;
  assign addr_o    = addr_q;
  assign wr_o      = wr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      all_q    <= 1'b0;
      cen_q    <= 1'b1;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      last_q   <= '0;
      base_q   <= '0;
      addr_q   <= '0;
    end else begin
      wr_q  <= ~cen_q;
      cen_q <= ~issue;
      if (last_wr_o) active_q <= 1'b0;
      if (start_i) begin
        active_q <= 1'b1;
        all_q    <= 1'b0;
        idx_q    <= '0;
        base_q   <= base_i;
        last_q   <= last_i;
      end
      if (issue) begin
        addr_q <= base_c + AW'(idx_c);
        if (idx_c == last_c) all_q <= 1'b1;
        else                 idx_q <= idx_c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: sequences one output-stationary convolution pass on the corelet.
// Per kernel position: load col weight rows into L0, kernel-load them, let
// the array settle, load len_nij activation rows, execute, and drain the
// OFIFO into pmem at kij*len_nij + n.
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle pulse, honoured only in IDLE
//   L0_full             L0 almost full (one slot still free while high)
//   ofifo_valid         OFIFO row valid this cycle
//   inst                corelet instruction (kload/exec/L0 write/L0 read)
//   xmem_cen/xmem_addr  activation/weight SRAM read port
//   pmem_cen/wen/addr   partial-sum SRAM write port
//   busy, done          status; done pulses one cycle after the last write
module core_ctrl
  import core_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_kij  = 9,
  parameter int len_nij  = 36,
  parameter int xaddr_bw = 11,
  parameter int paddr_bw = 11,
  parameter int w_base   = 0,
  parameter int x_base   = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                L0_full,
  input  logic                ofifo_valid,
  output logic [INST_W-1:0]   inst,
  output logic                xmem_cen,
  output logic [xaddr_bw-1:0] xmem_addr,
  output logic                pmem_cen,
  output logic                pmem_wen,
  output logic [paddr_bw-1:0] pmem_addr,
  output logic                busy,
  output logic                done
);

  localparam int CYC_W = clog2w(max2(max2(col, row + col), len_nij));
  localparam int KIJ_W = clog2w(len_kij);
  localparam int NIJ_W = clog2w(len_nij);
  localparam int STR_W = clog2w(max2(col, len_nij));

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [KIJ_W-1:0]   kij_q, kij_d, kij_inc;
  logic [NIJ_W-1:0]   drn_q, drn_d;
  logic               drn_all_q, drn_all_d;
  logic               drn_cnt, drn_last, drain_fin, adv;

  logic               str_start, str_wr, str_last_wr;
  logic [xaddr_bw-1:0] str_base;
  logic [STR_W-1:0]   str_last;

  logic               kload_q, exec_q, l0rd_q, busy_q, done_q, pcen_q;
  logic [paddr_bw-1:0] paddr_q;

  sram_rd_stream #(
    .AW (xaddr_bw),
    .CW (STR_W)
  ) u_stream (
    .clk_i     (clk),
    .rst_i     (reset),
    .start_i   (str_start),
    .base_i    (str_base),
    .last_i    (str_last),
    .L0_full_i (L0_full),
    .cen_o     (xmem_cen),
    .addr_o    (xmem_addr),
    .wr_o      (str_wr),
    .last_wr_o (str_last_wr)
  );

  // OFIFO rows are counted from X_EXEC entry, so rows that appear while the
  // array is still executing are not lost.
  assign drn_cnt   = ((state_q == S_X_EXEC) || (state_q == S_DRAIN)) && ofifo_valid && !drn_all_q;
  assign drn_last  = (drn_q == NIJ_W'(len_nij - 1));
  assign drain_fin = drn_all_q | (drn_cnt & drn_last);
  assign kij_inc   = kij_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q + 1'b1;
    kij_d     = kij_q;
    drn_d     = drn_q;
    drn_all_d = drn_all_q;
    adv       = 1'b0;
    str_start = 1'b0;
    str_base  = xaddr_bw'(x_base);
    str_last  = STR_W'(len_nij - 1);

    if (drn_cnt) begin
      if (drn_last) drn_all_d = 1'b1;
      else          drn_d     = drn_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (start) begin
          state_d   = S_W_LOAD;
          kij_d     = '0;
          str_start = 1'b1;
          str_base  = xaddr_bw'(w_base);
          str_last  = STR_W'(col - 1);
        end
      end
      S_W_LOAD: begin
        cyc_d = '0;
        if (str_last_wr) state_d = S_W_KERN;
      end
      S_W_KERN: begin
        if (cyc_q == CYC_W'(col - 1)) begin
          state_d = S_W_WAIT;
          cyc_d   = '0;
        end
      end
      S_W_WAIT: begin
        if (cyc_q == CYC_W'(row + col - 1)) begin
          state_d   = S_X_LOAD;
          cyc_d     = '0;
          str_start = 1'b1;
        end
      end
      S_X_LOAD: begin
        cyc_d = '0;
        if (str_last_wr) begin
          state_d   = S_X_EXEC;
          drn_d     = '0;
          drn_all_d = 1'b0;
        end
      end
      S_X_EXEC: begin
        if (cyc_q == CYC_W'(len_nij - 1)) begin
          cyc_d = '0;
          // If every row already drained during execution, skip DRAIN so
          // done still lands one cycle after the final pmem write.
          if (drain_fin) adv = 1'b1;
          else           state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cyc_d = '0;
        if (drain_fin) adv = 1'b1;
      end
      S_DONE: begin
        cyc_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      if (kij_q == KIJ_W'(len_kij - 1)) begin
        state_d = S_DONE;
      end else begin
        state_d   = S_W_LOAD;
        kij_d     = kij_inc;
        str_start = 1'b1;
        str_base  = xaddr_bw'(w_base + int'(kij_inc) * col);
        str_last  = STR_W'(col - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      kij_q     <= '0;
      drn_q     <= '0;
      drn_all_q <= 1'b0;
      kload_q   <= 1'b0;
      exec_q    <= 1'b0;
      l0rd_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pcen_q    <= 1'b1;
      paddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      kij_q     <= kij_d;
      drn_q     <= drn_d;
      drn_all_q <= drn_all_d;
      // Outputs decoded from the next state so they line up with state_q.
      kload_q   <= (state_d == S_W_KERN);
      exec_q    <= (state_d == S_X_EXEC);
      l0rd_q    <= (state_d == S_W_KERN) || (state_d == S_X_EXEC);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_q == S_DONE);
      pcen_q    <= ~drn_cnt;
      if (drn_cnt) paddr_q <= paddr_bw'(int'(kij_q) * len_nij + int'(drn_q));
    end
  end

  always_comb begin
    inst             = '0;
    inst[INST_KLOAD] = kload_q;
    inst[INST_EXEC]  = exec_q;
    inst[INST_L0WR]  = str_wr;
    inst[INST_L0RD]  = l0rd_q;
    inst[INST_ACC]   = 1'b0;
  end

  assign pmem_cen  = pcen_q;
  assign pmem_wen  = pcen_q;
  assign pmem_addr = paddr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl with default parameters. A negedge monitor
// tallies instruction bits, checks xmem/pmem address order, and models the
// OFIFO (one row per execute cycle, optionally gapped 1-on/3-off).
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        L0_full = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        xmem_cen, pmem_cen, pmem_wen, busy, done;
  logic [10:0] xmem_addr, pmem_addr;

  core_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .L0_full(L0_full),
    .ofifo_valid(ofifo_valid), .inst(inst), .xmem_cen(xmem_cen),
    .xmem_addr(xmem_addr), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
    .pmem_addr(pmem_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_mis = 0;

  // monitor / OFIFO-model state
  int cyc = 0, gap_mode = 0, pend = 0, phase = 0;
  int n_l0wr, n_kload, n_exec, n_done, n_pwr, n_wrd, n_xrd;
  int pexp, p_err, w_exp, w_err, x_idx, x_err, viol;
  int busy_rise, first_kload, first_exec, done_cyc, last_pwr;
  int snap_l0wr, snap_kload, snap_exec;
  logic busy_prev = 1'b0, l0f_prev = 1'b0;

  // stimulus helpers for the stall / start-in-drain pass
  int   k, stall_left;
  logic stalled, pulsed, in_pulse, seen_exec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_l0wr = 0; n_kload = 0; n_exec = 0; n_done = 0; n_pwr = 0; n_wrd = 0; n_xrd = 0;
    pexp = 0; p_err = 0; w_exp = 0; w_err = 0; x_idx = 0; x_err = 0; viol = 0;
    busy_rise = -1; first_kload = -1; first_exec = -1; done_cyc = -1; last_pwr = -1;
    snap_l0wr = -1; snap_kload = -1; snap_exec = -1;
    pend = 0; phase = 0; busy_prev = busy;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (n_done == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " done within budget"}, (n_done > 0), 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Monitor and OFIFO model; sole driver of ofifo_valid.
  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !busy_prev && busy_rise < 0) busy_rise = cyc;
      busy_prev = busy;
      if (inst[2]) n_l0wr++;
      if (inst[0]) begin
        n_kload++;
        if (first_kload < 0) first_kload = cyc;
      end
      if (inst[1]) begin
        n_exec++;
        pend++;
        if (first_exec < 0) first_exec = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (!pmem_cen && !pmem_wen) begin
        if (int'(pmem_addr) != pexp) p_err++;
        if (pmem_addr == 11'd35 && snap_l0wr < 0) begin
          snap_l0wr = n_l0wr; snap_kload = n_kload; snap_exec = n_exec;
        end
        pexp++;
        n_pwr++;
        last_pwr = cyc;
      end
      if (!xmem_cen) begin
        if (l0f_prev) viol++;
        if (xmem_addr < 11'd1024) begin
          if (int'(xmem_addr) != w_exp) w_err++;
          w_exp++;
          n_wrd++;
        end else begin
          if (int'(xmem_addr) != 1024 + x_idx) x_err++;
          x_idx = (x_idx + 1) % 36;
          n_xrd++;
        end
      end
      l0f_prev = L0_full;
      phase = (phase + 1) % 4;
      if (pend > 0 && (gap_mode == 0 || phase == 0)) begin
        ofifo_valid = 1'b1;
        pend--;
      end else begin
        ofifo_valid = 1'b0;
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst inst", inst, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst xmem_cen", xmem_cen, 1);
    check("rst xmem_addr", xmem_addr, 0);
    check("rst pmem_cen", pmem_cen, 1);
    check("rst pmem_wen", pmem_wen, 1);
    check("rst pmem_addr", pmem_addr, 0);

    // ---------------- pass A: full pass, no stall, continuous OFIFO -------
    clear_stats();
    gap_mode = 0;
    pulse_start();
    check("A busy after start", busy, 1);
    check("A first read cen", xmem_cen, 0);
    check("A first read addr", xmem_addr, 0);
    wait_done("A", 4000);
    check("A kload offset", first_kload - busy_rise, 9);
    check("A exec offset", first_exec - busy_rise, 70);
    check("A kij0 l0wr", snap_l0wr, 44);
    check("A kij0 kload", snap_kload, 8);
    check("A kij0 exec", snap_exec, 36);
    check("A l0wr total", n_l0wr, 396);
    check("A kload total", n_kload, 72);
    check("A exec total", n_exec, 324);
    check("A pmem writes", n_pwr, 324);
    check("A pmem order", p_err, 0);
    check("A weight reads", n_wrd, 72);
    check("A weight order", w_err, 0);
    check("A act reads", n_xrd, 324);
    check("A act order", x_err, 0);
    check("A done count", n_done, 1);
    check("A done after last write", done_cyc - last_pwr, 1);
    check("A idle busy", busy, 0);

    // ---------------- pass B: gapped OFIFO, L0 stall, start in DRAIN ------
    clear_stats();
    gap_mode = 1;
    pulse_start();
    k = 0; stall_left = 0;
    stalled = 1'b0; pulsed = 1'b0; in_pulse = 1'b0; seen_exec = 1'b0;
    while (n_done == 0 && k < 8000) begin
      @(posedge clk); #1;
      k++;
      if (in_pulse) begin
        start = 1'b0;
        in_pulse = 1'b0;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) L0_full = 1'b0;
      end
      if (!stalled && !xmem_cen && xmem_addr == 11'd1034) begin
        L0_full = 1'b1;
        stall_left = 5;
        stalled = 1'b1;
      end
      if (inst[1]) seen_exec = 1'b1;
      if (seen_exec && !inst[1] && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
        in_pulse = 1'b1;
      end
    end
    start = 1'b0;
    L0_full = 1'b0;
    check("B done within budget", (n_done > 0), 1);
    repeat (20) @(posedge clk);
    #1;
    check("B stall applied", stalled, 1);
    check("B start pulsed in drain", pulsed, 1);
    check("B no read while full", viol, 0);
    check("B act order", x_err, 0);
    check("B act reads", n_xrd, 324);
    check("B l0wr total", n_l0wr, 396);
    check("B pmem writes", n_pwr, 324);
    check("B pmem order", p_err, 0);
    check("B done count", n_done, 1);
    check("B done after last write", done_cyc - last_pwr, 1);
    check("B stays idle", busy, 0);

    // ---------------- reset in the middle of X_LOAD ----------------
    clear_stats();
    gap_mode = 0;
    pulse_start();
    k = 0;
    while (!(!xmem_cen && xmem_addr >= 11'd1024) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("R reached X_LOAD", (!xmem_cen && xmem_addr >= 11'd1024), 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("R inst", inst, 0);
    check("R xmem_cen", xmem_cen, 1);
    check("R busy", busy, 0);
    check("R pmem_cen", pmem_cen, 1);
    repeat (3) @(posedge clk);
    #1;
    check("R still idle", busy, 0);
    check("R no reads", xmem_cen, 1);

    // ---------------- pass C: clean pass after reset ----------------
    clear_stats();
    pulse_start();
    wait_done("C", 4000);
    check("C weight order", w_err, 0);
    check("C weight reads", n_wrd, 72);
    check("C pmem writes", n_pwr, 324);
    check("C pmem order", p_err, 0);
    check("C l0wr total", n_l0wr, 396);
    check("C done count", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Sequencer that drives the corelet instruction bus for one output-stationary convolution pass. For each of `len_kij` kernel positions it:
- streams `col` weight rows and then `len_nij` activation rows from activation/weight SRAM (xmem) into L0;
- issues the kernel-load and execute instructions;
- drains every OFIFO row into partial-sum SRAM (pmem) at a kij-indexed address.

It sits directly upstream of the corelet (produces `inst`, consumes `L0_full` and `ofifo_valid`) and alongside the two SRAMs.

## Interface
Parameters:
- `row`, 8: MAC array rows.
- `col`, 8: MAC array columns; weight rows per kij.
- `len_kij`, 9: kernel positions per pass.
- `len_nij`, 36: activation rows per kij.
- `xaddr_bw`, 11: xmem address width.
- `paddr_bw`, 11: pmem address width.
- `w_base`, 0: xmem address of kij 0 weight row 0.
- `x_base`, 1024: xmem address of activation row 0.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a pass from IDLE.
- `L0_full`  in  1  L0 almost-full: at least one free entry remains while high.
- `ofifo_valid`  in  1  OFIFO presents a valid row on `out_mac` this cycle.
- `inst`  out  34  corelet instruction:
  - [0] kernel load;
  - [1] execute;
  - [2] L0 write;
  - [3] L0 read;
  - all other bits 0.
- `xmem_cen`  out  1  xmem chip enable, active low.
- `xmem_addr`  out  xaddr_bw  xmem read address.
- `pmem_cen`  out  1  pmem chip enable, active low.
- `pmem_wen`  out  1  pmem write enable, active low.
- `pmem_addr`  out  paddr_bw  pmem write address.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the pass completes.

## Operation
States: IDLE → W_LOAD → W_KERN → W_WAIT → X_LOAD → X_EXEC → DRAIN, then → W_LOAD for the next kij, or → DONE → IDLE.

- **IDLE:** `start` → W_LOAD with kij=0. `start` is ignored in every other state.
- **W_LOAD:** issues `col` xmem reads at `w_base + kij*col + i`.
  - A read issues only in cycles where `L0_full` is low.
  - Each read asserts `xmem_cen` low for that cycle.
  - `inst[2]` is asserted exactly one cycle after each issued read (1-cycle SRAM latency).
  - Leaves when all `col` reads are issued and the last write has been registered.
- **W_KERN:** `col` cycles with `inst[3]`=1 and `inst[0]`=1.
- **W_WAIT:** `row+col` idle cycles so weights settle in the array.
- **X_LOAD:** same as W_LOAD, but issues `len_nij` reads at `x_base + j`. Activations are reused for every kij.
- **X_EXEC:** `len_nij` cycles with `inst[3]`=1 and `inst[1]`=1.
- **DRAIN:** counts `ofifo_valid` cycles until `len_nij` is reached.
  - Each such cycle drives `pmem_cen`=0, `pmem_wen`=0, `pmem_addr` = `kij*len_nij + n`, where n is the drain count before increment.
  - `ofifo_valid` is also counted if it rises during X_EXEC; the drain count starts at the X_EXEC entry.
  - On reaching the count: kij+1 < `len_kij` → W_LOAD; otherwise → DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Counters:** all sized to `$clog2` of their bound and compared against bound-1. Address products are computed at full counter width and truncated to the address width.
- **Reset:** synchronous reset from any state, mid-pass included, returns to IDLE and zeroes all counters.

## Timing
- Reset values:
  - `inst`=0, `busy`=0, `done`=0, both address outputs 0;
  - `xmem_cen`=1, `pmem_cen`=1, `pmem_wen`=1.
- All outputs are registered; no combinational input-to-output path.
- `start` sampled in cycle t → `busy` and the first `xmem_cen`=0 both in cycle t+1.
- Stall:
  - `L0_full` high in cycle t → no read issued in t; the address holds.
  - A read issued in t-1 still produces `inst[2]` in t. This is legal because `L0_full` reserves one slot.
- Stall-free duration of one kij = `2*col + (row+col) + 2*len_nij + 2` cycles, plus the DRAIN wait.
- `done` rises exactly one cycle after the pmem write of the last row (kij=`len_kij`-1, n=`len_nij`-1).

## Structure
- Shared package `core_pkg`:
  - state enum;
  - `inst` bit-index constants INST_KLOAD=0, INST_EXEC=1, INST_L0WR=2, INST_L0RD=3, INST_ACC=33.
- One natural sub-module, `sram_rd_stream`: issues N xmem reads with `L0_full` backpressure and emits the delayed write strobe. W_LOAD and X_LOAD both reuse it with different base and count.

## Test plan
- **Reset mid-X_LOAD:** assert reset in X_LOAD → next cycle IDLE, `inst`=0, `xmem_cen`=1, `busy`=0. A following `start` runs a clean pass.
- **Single kij, no stall, default params, OFIFO model returning 36 valid rows:** expect `inst[2]` pulses = 8+36, `inst[0]` cycles = 8, `inst[1]` cycles = 36, pmem writes to addresses 0..35, and `done` once.
- **Full pass, `len_kij`=9:** pmem addresses 0..323 each written exactly once, in order; xmem weight addresses 0..71 read once; `done` after address 323.
- **`L0_full` high for 5 cycles mid-X_LOAD:** reads resume at the held address with no skip or duplicate; exactly 36 `inst[2]` pulses in X_LOAD.
- **`start` pulsed during DRAIN:** ignored; exactly one `done`.
- **`ofifo_valid` gapped (1 cycle on, 3 off):** DRAIN lasts until 36 valid cycles; pmem addresses stay contiguous.
